// File: rtl/mem_2p_be.sv
// rtl/mem_2p_be.sv - simple dual-port RAM with lane write enables, 1/2-cycle read latency and clear sweep
// Optional feature macro: MEM_WR_BYPASS_EN (write-first forwarding on same-address read/write)
module mem_2p_be #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int MAX_ADDR   = 8,
    parameter int ADDRSIZE   = $clog2(MAX_ADDR),
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr_req,
    output logic                             busy,
    input  logic                             rd_en,
    input  logic [ADDRSIZE-1:0]              rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             wr_en,
    input  logic [ADDRSIZE-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [ADDRSIZE-1:0] LAST_ADDR  = ADDRSIZE'(MAX_ADDR - 1);
    localparam logic [ADDRSIZE:0]   ADDR_LIMIT = (ADDRSIZE + 1)'(MAX_ADDR);

    logic [0:0]            state;
    logic [ADDRSIZE-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0] mem [MAX_ADDR];

    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rd_in_range;
    logic                  wr_in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    assign busy        = reset || (state == ST_CLEAR);
    // The cycle that accepts clr_req also drops any read/write issued alongside it.
    assign accept      = !busy && !clr_req;
    assign rd_acc      = rd_en && accept;
    assign wr_acc      = wr_en && accept;
    assign rd_in_range = {1'b0, rd_addr} < ADDR_LIMIT;
    assign wr_in_range = {1'b0, wr_addr} < ADDR_LIMIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                state <= ST_IDLE;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end else if (clr_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end
    end

    // No reset on the array itself so it can map onto block RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (wr_acc && wr_in_range) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_be[i]) begin
                        mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
`ifdef MEM_WR_BYPASS_EN
            if (wr_acc && (wr_addr == rd_addr)) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_be[i]) begin
                        rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
`endif
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  p1_valid;
            logic [DATA_WIDTH-1:0] p1_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    p1_valid <= 1'b0;
                    p1_data  <= '0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    p1_valid <= rd_acc;
                    if (rd_acc) begin
                        p1_data <= rd_word;
                    end
                    rd_valid <= p1_valid;
                    if (p1_valid) begin
                        rd_data <= p1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= rd_word;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_mem_2p_be.sv
// tb/tb_mem_2p_be.sv - directed bench for mem_2p_be: 8-word latency 1, 8-word latency 2, 6-word latency 1
module tb_mem_2p_be;
    logic        clk = 1'b0;
    logic        reset, clr_req, rd_en, wr_en;
    logic [2:0]  rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        busy_a, busy_b, busy_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic [15:0] rd_data_a, rd_data_b, rd_data_c;

    int checks = 0;
    int failures = 0;

`ifdef MEM_WR_BYPASS_EN
    localparam logic [15:0] EXP_COL = 16'h0007;
`else
    localparam logic [15:0] EXP_COL = 16'h0003;
`endif

    always #5 clk = ~clk;

    mem_2p_be #(.DATA_WIDTH(16), .LANE_WIDTH(8), .MAX_ADDR(8), .RD_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be));

    mem_2p_be #(.DATA_WIDTH(16), .LANE_WIDTH(8), .MAX_ADDR(8), .RD_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be));

    mem_2p_be #(.DATA_WIDTH(16), .LANE_WIDTH(8), .MAX_ADDR(6), .RD_LATENCY(1)) dut_c (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_c),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be));

    task automatic write_word(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int n_a, n_b, n_c;
        reset = 1'b1; clr_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy_a !== 1'b1 || busy_c !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b%b exp=11", busy_a, busy_c); end
        checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b%b exp=00", rd_valid_a, rd_valid_b); end
        checks++; if (rd_data_a !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data_a); end
        reset = 1'b0; #1;
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) n_a++;
            if (busy_b) n_b++;
            if (busy_c) n_c++;
            @(negedge clk);
        end
        checks++; if (n_a != 8) begin failures++; $display("FAIL sweep_busy_a got=%0d exp=8", n_a); end
        checks++; if (n_b != 8) begin failures++; $display("FAIL sweep_busy_b got=%0d exp=8", n_b); end
        checks++; if (n_c != 6) begin failures++; $display("FAIL sweep_busy_c got=%0d exp=6", n_c); end
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            @(negedge clk);
            checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0) begin failures++; $display("FAIL sweep_read[%0d] got=%b/%h exp=1/0000", a, rd_valid_a, rd_data_a); end
        end
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lane_write();
        write_word(3'd3, 16'hABCD, 2'b11);
        write_word(3'd3, 16'h12EE, 2'b10);
        rd_en = 1'b1; rd_addr = 3'd3;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h12CD) begin failures++; $display("FAIL lane_rd_a got=%b/%h exp=1/12cd", rd_valid_a, rd_data_a); end
        @(negedge clk);
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h12CD) begin failures++; $display("FAIL lane_rd_b got=%b/%h exp=1/12cd", rd_valid_b, rd_data_b); end
        checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL lane_single_pulse got=%b exp=0", rd_valid_a); end
        write_word(3'd3, 16'hFFFF, 2'b00);
        rd_en = 1'b1; rd_addr = 3'd0;
        @(negedge clk);
        rd_addr = 3'd3;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h12CD) begin failures++; $display("FAIL be_zero_noop got=%b/%h exp=1/12cd", rd_valid_a, rd_data_a); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic        ev1, ev2;
        logic [15:0] ed1, ed2;
        for (int i = 0; i < 4; i++) write_word(3'(i), 16'(i + 1), 2'b11);
        for (int i = 0; i < 7; i++) begin
            rd_en = (i < 4); rd_addr = 3'(i % 4);
            @(negedge clk);
            ev1 = (i < 4);            ed1 = 16'(i + 1);
            ev2 = (i >= 1 && i <= 4); ed2 = 16'(i);
            checks++; if (rd_valid_a !== ev1 || (ev1 && rd_data_a !== ed1)) begin failures++; $display("FAIL b2b_lat1[%0d] got=%b/%h exp=%b/%h", i, rd_valid_a, rd_data_a, ev1, ed1); end
            checks++; if (rd_valid_b !== ev2 || (ev2 && rd_data_b !== ed2)) begin failures++; $display("FAIL b2b_lat2[%0d] got=%b/%h exp=%b/%h", i, rd_valid_b, rd_data_b, ev2, ed2); end
            checks++; if (rd_valid_c !== ev1 || (ev1 && rd_data_c !== ed1)) begin failures++; $display("FAIL b2b_c[%0d] got=%b/%h exp=%b/%h", i, rd_valid_c, rd_data_c, ev1, ed1); end
        end
    endtask

    task automatic test_collision();
        write_word(3'd1, 16'h0003, 2'b11);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0007; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 3'd1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== EXP_COL) begin failures++; $display("FAIL collision_a got=%b/%h exp=1/%h", rd_valid_a, rd_data_a, EXP_COL); end
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (rd_data_a !== 16'h0007) begin failures++; $display("FAIL collision_after_a got=%h exp=0007", rd_data_a); end
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== EXP_COL) begin failures++; $display("FAIL collision_b got=%b/%h exp=1/%h", rd_valid_b, rd_data_b, EXP_COL); end
        @(negedge clk);
        checks++; if (rd_data_b !== 16'h0007) begin failures++; $display("FAIL collision_after_b got=%h exp=0007", rd_data_b); end
    endtask

    task automatic test_clear();
        write_word(3'd2, 16'h5555, 2'b11);
        rd_en = 1'b1; rd_addr = 3'd2;
        @(negedge clk);
        checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h5555) begin failures++; $display("FAIL preclear_rd_a got=%b/%h exp=1/5555", rd_valid_a, rd_data_a); end
        rd_en = 1'b0; clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hAAAA; wr_be = 2'b11;
        @(negedge clk);
        clr_req = 1'b0; wr_en = 1'b0;
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h5555) begin failures++; $display("FAIL inflight_rd_b got=%b/%h exp=1/5555", rd_valid_b, rd_data_b); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL clr_busy got=%b exp=1", busy_a); end
        rd_en = 1'b1; rd_addr = 3'd2;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin failures++; $display("FAIL busy_read_n3 got=%b%b exp=00", rd_valid_a, rd_valid_b); end
        @(negedge clk);
        checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin failures++; $display("FAIL busy_read_n4 got=%b%b exp=00", rd_valid_a, rd_valid_b); end
        for (int i = 0; i < 20 && (busy_a || busy_b || busy_c); i++) @(negedge clk);
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL clr_done got=%b%b exp=00", busy_a, busy_b); end
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            @(negedge clk);
            checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0) begin failures++; $display("FAIL clr_read[%0d] got=%b/%h exp=1/0000", a, rd_valid_a, rd_data_a); end
        end
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        int n_c;
        write_word(3'd5, 16'h1234, 2'b11);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy_c !== 1'b1 || rd_valid_c !== 1'b0) begin failures++; $display("FAIL midreset_state got=%b/%b exp=1/0", busy_c, rd_valid_c); end
        reset = 1'b0; #1;
        n_c = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_c) n_c++;
            @(negedge clk);
        end
        checks++; if (n_c != 6) begin failures++; $display("FAIL midreset_busy got=%0d exp=6", n_c); end
        for (int a = 0; a < 6; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            @(negedge clk);
            checks++; if (rd_valid_c !== 1'b1 || rd_data_c !== 16'h0) begin failures++; $display("FAIL midreset_read[%0d] got=%b/%h exp=1/0000", a, rd_valid_c, rd_data_c); end
        end
        rd_en = 1'b0;
        write_word(3'd5, 16'h00FF, 2'b11);
        write_word(3'd7, 16'hBEEF, 2'b11);
        rd_en = 1'b1; rd_addr = 3'd5;
        @(negedge clk);
        checks++; if (rd_valid_c !== 1'b1 || rd_data_c !== 16'h00FF) begin failures++; $display("FAIL oor_prior got=%b/%h exp=1/00ff", rd_valid_c, rd_data_c); end
        rd_addr = 3'd7;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (rd_valid_c !== 1'b1 || rd_data_c !== 16'h0) begin failures++; $display("FAIL oor_read got=%b/%h exp=1/0000", rd_valid_c, rd_data_c); end
        @(negedge clk);
        checks++; if (rd_valid_c !== 1'b0) begin failures++; $display("FAIL oor_single_pulse got=%b exp=0", rd_valid_c); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lane_write();
        test_back_to_back();
        test_collision();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
